// File: rtl/cmp.sv
// rtl/cmp.sv - branch-condition comparator with registered flag and optional taken counter (CMP_STATS_EN)
module cmp #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    output logic             Br,
    output logic             Br_r,
    output logic [CNT_W-1:0] Cnt
);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLEZ = 3'd2;
    localparam logic [2:0] OP_BGTZ = 3'd3;
    localparam logic [2:0] OP_BLTZ = 3'd4;
    localparam logic [2:0] OP_BGEZ = 3'd5;

    logic w_eq;
    logic w_neg;
    logic w_zero;
    logic w_br;
    logic r_br_r;

    // Shared condition terms: full bitwise equality and the sign/zero view of A
    always_comb begin
        w_eq   = (A == B);
        w_neg  = A[WIDTH-1];
        w_zero = (A == '0);
    end

    // Condition select; reserved and unknown opcodes fall through to not-taken
    always_comb begin
        w_br = 1'b0;
        case (Op)
            OP_BEQ:  w_br = w_eq;
            OP_BNE:  w_br = ~w_eq;
            OP_BLEZ: w_br = w_neg | w_zero;
            OP_BGTZ: w_br = ~w_neg & ~w_zero;
            OP_BLTZ: w_br = w_neg;
            OP_BGEZ: w_br = ~w_neg;
            default: w_br = 1'b0;
        endcase
    end

    assign Br = w_br;

    // Registered copy of the flag; reset wins over a simultaneous true condition
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_r <= 1'b0;
        end else begin
            r_br_r <= w_br;
        end
    end

    assign Br_r = r_br_r;

`ifdef CMP_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    // Taken-branch counter; wraps silently from all-ones to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_br) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Cnt = r_cnt;
`else
    assign Cnt = '0;
`endif

endmodule

// File: tb/tb_cmp.sv
// tb/tb_cmp.sv - self-checking bench for cmp (counter checks active when CMP_STATS_EN is defined)
module tb_cmp;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  Op;
    logic        Br;
    logic        Br_r;
    logic [31:0] Cnt;

    int checks = 0;
    int errors = 0;

    logic        m_br_r;
    logic [31:0] m_cnt;

    cmp #(.WIDTH(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .Op    (Op),
        .Br    (Br),
        .Br_r  (Br_r),
        .Cnt   (Cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: branch outcome from signed integer arithmetic
    function automatic logic model_br(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int sa;
        sa = a;
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return sa <= 0;
            3'd3:    return sa > 0;
            3'd4:    return sa < 0;
            3'd5:    return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: apply inputs, check Br, clock, check Br_r and Cnt against the model
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic rst, input string tag);
        logic e;
        A = a; B = b; Op = op; reset = rst;
        #1;
        e = model_br(a, b, op);
        chk({tag, ".Br"}, {31'b0, Br}, {31'b0, e});
        @(posedge clk);
        m_br_r = rst ? 1'b0 : e;
`ifdef CMP_STATS_EN
        if (rst) m_cnt = '0;
        else if (e) m_cnt = m_cnt + 1;
`else
        m_cnt = '0;
`endif
        #1;
        chk({tag, ".Br_r"}, {31'b0, Br_r}, {31'b0, m_br_r});
        chk({tag, ".Cnt"}, Cnt, m_cnt);
    endtask

    initial begin
        m_br_r = 1'b0;
        m_cnt  = '0;
        reset = 1'b1; A = '0; B = '0; Op = 3'd6;

        // Reset state
        step(32'd0, 32'd0, 3'd6, 1'b1, "rst0");
        step(32'd0, 32'd0, 3'd6, 1'b1, "rst1");
        chk("reset.Br_r", {31'b0, Br_r}, 32'd0);
        chk("reset.Cnt", Cnt, 32'd0);

        // Directed equality cases
        step(32'd1, 32'd1, 3'd0, 1'b0, "beq_eq");
        chk("beq_eq.Br_r_one", {31'b0, Br_r}, 32'd1);
        step(32'd1, 32'd1, 3'd1, 1'b0, "bne_eq");
        step(32'd5, 32'd9, 3'd0, 1'b0, "beq_ne");
        step(32'd5, 32'd9, 3'd1, 1'b0, "bne_ne");

        // Sign boundaries
        for (int op = 2; op <= 5; op++) step(32'h8000_0000, 32'd0, op[2:0], 1'b0, "min_neg");
        for (int op = 2; op <= 5; op++) step(32'd0, 32'd0, op[2:0], 1'b0, "zero");
        for (int op = 2; op <= 5; op++) step(32'h7FFF_FFFF, 32'd0, op[2:0], 1'b0, "max_pos");
        for (int op = 2; op <= 5; op++) step(32'hFFFF_FFFF, 32'd7, op[2:0], 1'b0, "minus1");

        // Reserved opcodes
        step(32'd3, 32'd3, 3'd6, 1'b0, "rsv6");
        step(32'd3, 32'd3, 3'd7, 1'b0, "rsv7");

        // Reset held with a true condition, then released
        step(32'd3, 32'd3, 3'd0, 1'b1, "rst_true");
        chk("rst_true.Br_r_zero", {31'b0, Br_r}, 32'd0);
        chk("rst_true.Cnt_zero", Cnt, 32'd0);
        step(32'd3, 32'd3, 3'd0, 1'b0, "rst_rel");
        chk("rst_rel.Br_r_one", {31'b0, Br_r}, 32'd1);

        // Unknown inputs must not stick: valid inputs resolve immediately
        A = 'x; B = 32'd4; Op = 3'd0;
        #1;
        A = 32'd4;
        #1;
        chk("x_recover.Br", {31'b0, Br}, 32'd1);
        Op = 3'bxxx;
        #1;
        Op = 3'd1;
        #1;
        chk("x_recover_op.Br", {31'b0, Br}, 32'd0);
        @(negedge clk);

`ifdef CMP_STATS_EN
        // Counter: 10 taken, 3 not taken
        step(32'd0, 32'd0, 3'd6, 1'b1, "cnt_rst");
        for (int i = 0; i < 10; i++) step(32'd8, 32'd8, 3'd0, 1'b0, "cnt_taken");
        for (int i = 0; i < 3; i++) step(32'd8, 32'd8, 3'd7, 1'b0, "cnt_idle");
        chk("cnt_ten", Cnt, 32'd10);
`endif

        // Randomized operands, biased toward equality and boundary values
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            logic [2:0]  rop;
            logic        rr;
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'd0;
                1: ra = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rop = 3'($urandom_range(0, 7));
            rr  = ($urandom_range(0, 19) == 0);
            step(ra, rb, rop, rr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
